// File: rtl/stack_nbits_if.sv
// Bundle of the operand-stack request and status signals shared between the
// calculator datapath (master) and the stack itself (slave).
interface stack_nbits_if #(
   parameter int width = 8,
   parameter int depth = 4
);
   logic                         clear_i;
   logic                         push_i;
   logic                         pop_i;
   logic [width-1:0]             d_i;
   logic [width-1:0]             top_o;
   logic [width-1:0]             next_o;
   logic [$clog2(depth+1)-1:0]   count_o;
   logic                         empty_o;
   logic                         full_o;
   logic                         err_o;

   modport master (
      output clear_i, push_i, pop_i, d_i,
      input  top_o, next_o, count_o, empty_o, full_o, err_o
   );

   modport slave (
      input  clear_i, push_i, pop_i, d_i,
      output top_o, next_o, count_o, empty_o, full_o, err_o
   );
endinterface

// File: rtl/stack_nbits.sv
// LIFO operand stack for the calculator datapath. Holds up to depth words,
// exposes the two topmost operands for the ALU and supports push, pop and
// replace (push and pop together overwrite the top word). Overflow and
// underflow attempts leave the contents untouched and set a sticky error.
module stack_nbits #(
   parameter int width = 8,
   parameter int depth = 4
) (
   input logic          clock_i,
   input logic          reset_i,
   stack_nbits_if.slave bus
);
   localparam int cw = $clog2(depth + 1);
   localparam int aw = $clog2(depth);

   logic [width-1:0] entries [depth];
   logic [cw-1:0]    count;
   logic             err;
   logic [aw-1:0]    top_idx;
   logic [aw-1:0]    next_idx;
   logic [aw-1:0]    wr_idx;
   logic             is_empty;
   logic             is_full;

   // Index arithmetic; out-of-range values for small counts are masked below.
   always_comb begin
      top_idx  = aw'(count - cw'(1));
      next_idx = aw'(count - cw'(2));
      wr_idx   = aw'(count);
      is_empty = (count == '0);
      is_full  = (count == cw'(depth));
   end

   // Stack state update: reset and clear empty the stack, otherwise decode push/pop.
   always_ff @(posedge clock_i) begin
      if (reset_i || bus.clear_i) begin
         for (int i = 0; i < depth; i++) begin
            entries[i] <= '0;
         end
         count <= '0;
         err   <= 1'b0;
      end else begin
         case ({bus.push_i, bus.pop_i})
            2'b10: begin
               if (is_full) begin
                  err <= 1'b1;
               end else begin
                  entries[wr_idx] <= bus.d_i;
                  count           <= count + cw'(1);
               end
            end
            2'b01: begin
               if (is_empty) begin
                  err <= 1'b1;
               end else begin
                  entries[top_idx] <= '0;
                  count            <= count - cw'(1);
               end
            end
            2'b11: begin
               if (is_empty) begin
                  err <= 1'b1;
               end else begin
                  entries[top_idx] <= bus.d_i;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs are derived purely from state; operands are zero when not present.
   always_comb begin
      bus.top_o   = (count >= cw'(1)) ? entries[top_idx]  : '0;
      bus.next_o  = (count >= cw'(2)) ? entries[next_idx] : '0;
      bus.count_o = count;
      bus.empty_o = is_empty;
      bus.full_o  = is_full;
      bus.err_o   = err;
   end
endmodule

// File: tb/tb_stack_nbits.sv
// Testbench for stack_nbits: drives one operation per clock, predicts the
// resulting outputs with a queue-based reference stack, pushes the prediction
// into a scoreboard and compares it against the DUT after the edge.
module tb_stack_nbits;
   localparam int W = 8;
   localparam int D = 4;

   typedef struct {
      logic [W-1:0] top;
      logic [W-1:0] next;
      logic [2:0]   count;
      logic         empty;
      logic         full;
      logic         err;
   } exp_t;

   logic clock_i;
   logic reset_i;

   stack_nbits_if #(.width(W), .depth(D)) bus ();

   stack_nbits #(.width(W), .depth(D)) dut (
      .clock_i(clock_i),
      .reset_i(reset_i),
      .bus    (bus)
   );

   exp_t         scoreboard[$];
   logic [W-1:0] model[$];
   logic         model_err;
   int           check_count;
   int           fail_count;

   // Free-running 10 ns clock.
   initial begin
      clock_i = 1'b0;
      forever #5 clock_i = ~clock_i;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic clr, input logic push,
                                input logic pop, input logic [W-1:0] d);
      exp_t e;
      exp_t got;
      @(negedge clock_i);
      reset_i     = rst;
      bus.clear_i = clr;
      bus.push_i  = push;
      bus.pop_i   = pop;
      bus.d_i     = d;
      if (rst || clr) begin
         model.delete();
         model_err = 1'b0;
      end else if (push && !pop) begin
         if (model.size() == D) model_err = 1'b1;
         else model.push_back(d);
      end else if (!push && pop) begin
         if (model.size() == 0) model_err = 1'b1;
         else void'(model.pop_back());
      end else if (push && pop) begin
         if (model.size() == 0) model_err = 1'b1;
         else model[model.size()-1] = d;
      end
      e.count = 3'(model.size());
      e.top   = (model.size() > 0) ? model[model.size()-1] : '0;
      e.next  = (model.size() > 1) ? model[model.size()-2] : '0;
      e.empty = (model.size() == 0);
      e.full  = (model.size() == D);
      e.err   = model_err;
      scoreboard.push_back(e);
      @(posedge clock_i);
      #1;
      got = scoreboard.pop_front();
      checkOutput("top",   32'(bus.top_o),   32'(got.top));
      checkOutput("next",  32'(bus.next_o),  32'(got.next));
      checkOutput("count", 32'(bus.count_o), 32'(got.count));
      checkOutput("empty", 32'(bus.empty_o), 32'(got.empty));
      checkOutput("full",  32'(bus.full_o),  32'(got.full));
      checkOutput("err",   32'(bus.err_o),   32'(got.err));
   endtask

   // Directed scenarios followed by a randomised operation mix.
   initial begin
      check_count = 0;
      fail_count  = 0;
      model_err   = 1'b0;
      reset_i     = 1'b1;
      bus.clear_i = 1'b0;
      bus.push_i  = 1'b0;
      bus.pop_i   = 1'b0;
      bus.d_i     = '0;

      // Reset dominates a held push.
      applyStimulus(1, 0, 1, 0, 8'hAA);
      applyStimulus(1, 0, 1, 0, 8'hAA);
      checkOutput("reset_count_const", 32'(bus.count_o), 32'd0);

      // Fill, then overflow.
      applyStimulus(0, 0, 1, 0, 8'h11);
      applyStimulus(0, 0, 1, 0, 8'h22);
      applyStimulus(0, 0, 1, 0, 8'h33);
      applyStimulus(0, 0, 1, 0, 8'h44);
      checkOutput("full_top_const", 32'(bus.top_o), 32'h44);
      applyStimulus(0, 0, 1, 0, 8'h55);
      checkOutput("overflow_err_const", 32'(bus.err_o), 32'd1);
      // Replace on full stack is legal, error stays sticky.
      applyStimulus(0, 0, 1, 1, 8'h66);

      // Clear, then underflow.
      applyStimulus(0, 1, 1, 0, 8'h99);
      applyStimulus(0, 0, 0, 1, 8'h00);
      checkOutput("underflow_err_const", 32'(bus.err_o), 32'd1);
      // Ops continue normally while error is sticky.
      applyStimulus(0, 0, 1, 0, 8'h21);
      applyStimulus(0, 1, 0, 0, 8'h00);

      // Push, replace, pop.
      applyStimulus(0, 0, 1, 0, 8'h05);
      applyStimulus(0, 0, 1, 0, 8'h03);
      applyStimulus(0, 0, 1, 1, 8'h08);
      checkOutput("replace_top_const", 32'(bus.top_o), 32'h08);
      applyStimulus(0, 0, 0, 1, 8'h00);
      checkOutput("pop_next_const", 32'(bus.next_o), 32'h00);
      applyStimulus(0, 0, 0, 0, 8'hEE);
      applyStimulus(0, 0, 0, 1, 8'h00);

      // Replace on empty stack.
      applyStimulus(0, 0, 1, 1, 8'h7F);

      // Reset mid-sequence with pop asserted.
      applyStimulus(0, 0, 1, 0, 8'hA1);
      applyStimulus(0, 0, 1, 0, 8'hA2);
      applyStimulus(0, 0, 1, 0, 8'hA3);
      applyStimulus(1, 0, 0, 1, 8'h00);
      applyStimulus(0, 0, 1, 0, 8'h01);
      checkOutput("post_reset_top_const", 32'(bus.top_o), 32'h01);

      // Random mix biased toward pushes so the stack reaches full often.
      for (int i = 0; i < 300; i++) begin
         logic r;
         logic c;
         logic pu;
         logic po;
         r  = ($urandom_range(0, 63) == 0);
         c  = ($urandom_range(0, 31) == 0);
         pu = ($urandom_range(0, 9) < 6);
         po = ($urandom_range(0, 9) < 4);
         applyStimulus(r, c, pu, po, W'($urandom));
      end

      applyStimulus(0, 0, 0, 0, 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end
endmodule
